// File: rtl/nibble_cpu_v2.sv
// -----------------------------------------------------------------------------
// nibble_cpu_v2 -- parametrised accumulator CPU with a narrow memory bus.
//
// Fetches three DW-bit instruction words per instruction (opcode, reg/mode,
// operand), optionally loads a memory operand, then executes. Registers A, X, Y
// plus Z/C flags. Every bus cycle (F1/F2/F3/LOAD/STORE) completes only on a clk
// edge with bus_ready=1; EXEC takes exactly one cycle; HALT holds until reset.
//
// Ports
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   bus_addr   out  [AW+1:0] bus address (fetch, operand or store address)
//   bus_cmd    out  [2:0] 000 idle, 001 F1, 010 F2, 011 F3, 100 LOAD, 101 STORE
//   bus_we     out  write strobe, high only in STORE
//   bus_wdata  out  [DW-1:0] store data, 0 outside STORE
//   bus_rdata  in   [DW-1:0] read data, sampled when F1/F2/F3/LOAD completes
//   bus_ready  in   bus cycle completes on an edge where this is 1
//   halted     out  high in HALT
// -----------------------------------------------------------------------------
module nibble_cpu_v2 #(
   parameter int DW = 4,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic [AW+1:0] bus_addr,
   output logic [2:0]    bus_cmd,
   output logic          bus_we,
   output logic [DW-1:0] bus_wdata,
   input  logic [DW-1:0] bus_rdata,
   input  logic          bus_ready,
   output logic          halted
);

   // Jump targets use the low min(DW,AW) bits of the operand value.
   localparam int TW = (DW < AW) ? DW : AW;

   typedef enum logic [6:0] {
      S_F1    = 7'b0000001,
      S_F2    = 7'b0000010,
      S_F3    = 7'b0000100,
      S_LOAD  = 7'b0001000,
      S_EXEC  = 7'b0010000,
      S_STORE = 7'b0100000,
      S_HALT  = 7'b1000000
   } state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] pc;
   logic [3:0]    opc;       // w0[3:0]
   logic [3:0]    fld;       // w1[3:0]: {reg, mode}
   logic [DW-1:0] opnd;      // w2
   logic [DW-1:0] mval;      // value returned by LOAD
   logic [DW-1:0] ra, rx, ry;
   logic          z, c;

   logic [DW-1:0] sel_reg, eff_addr, value, alu_res;
   logic          alu_c, wr_reg, upd_z, do_jump;
   logic [AW-1:0] jmp_tgt;
   logic          nop_op;

   // Register select: code 11 falls back to A.
   always_comb begin
      case (fld[3:2])
         2'b01:   sel_reg = rx;
         2'b10:   sel_reg = ry;
         default: sel_reg = ra;
      endcase
   end

   // Indexed mode wraps naturally in DW bits; mode 11 behaves as direct.
   assign eff_addr = (fld[1:0] == 2'b10) ? opnd + rx : opnd;
   assign value    = (fld[1:0] == 2'b00) ? opnd : mval;
   assign nop_op   = (opc == 4'hC) || (opc == 4'hD) || (opc == 4'hE);

   always_comb begin
      jmp_tgt          = '0;
      jmp_tgt[TW-1:0]  = value[TW-1:0];
   end

   // ALU / branch decode for EXEC.
   // NOTE: every combinational output gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      alu_res = sel_reg;
      alu_c   = c;
      wr_reg  = 1'b0;
      upd_z   = 1'b0;
      do_jump = 1'b0;
      case (opc)
         4'h0: begin alu_res = value;             wr_reg = 1'b1; upd_z = 1'b1; end
         4'h2: begin
            {alu_c, alu_res} = {1'b0, sel_reg} + {1'b0, value};
            wr_reg = 1'b1; upd_z = 1'b1;
         end
         4'h3, 4'h7: begin
            alu_res = sel_reg - value;
            alu_c   = (sel_reg >= value);
            wr_reg  = (opc == 4'h3);
            upd_z   = 1'b1;
         end
         4'h4: begin alu_res = sel_reg & value;   wr_reg = 1'b1; upd_z = 1'b1; end
         4'h5: begin alu_res = sel_reg | value;   wr_reg = 1'b1; upd_z = 1'b1; end
         4'h6: begin alu_res = sel_reg ^ value;   wr_reg = 1'b1; upd_z = 1'b1; end
         4'h8: do_jump = 1'b1;
         4'h9: do_jump = z;
         4'hA: do_jump = c;
         4'hB: do_jump = ~z;
         default: ;
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_F1:    if (bus_ready) state_nxt = S_F2;
         S_F2:    if (bus_ready) state_nxt = S_F3;
         S_F3:
            if (bus_ready) begin
               if (opc == 4'h1)                           state_nxt = S_STORE;
               else if (opc == 4'hF)                      state_nxt = S_HALT;
               else if (fld[1:0] != 2'b00 && !nop_op)     state_nxt = S_LOAD;
               else                                       state_nxt = S_EXEC;
            end
         S_LOAD:  if (bus_ready) state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_F1;
         S_STORE: if (bus_ready) state_nxt = S_F1;
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_F1;
      endcase
   end

   // Bus outputs decode purely from registered state, so they hold steady
   // through wait states and bus_we falls the instant reset is asserted.
   always_comb begin
      bus_addr  = '0;
      bus_cmd   = 3'b000;
      bus_we    = 1'b0;
      bus_wdata = '0;
      halted    = 1'b0;
      case (state)
         S_F1:    begin bus_addr = {pc, 2'b00}; bus_cmd = 3'b001; end
         S_F2:    begin bus_addr = {pc, 2'b01}; bus_cmd = 3'b010; end
         S_F3:    begin bus_addr = {pc, 2'b10}; bus_cmd = 3'b011; end
         S_LOAD:  begin bus_addr[DW-1:0] = eff_addr; bus_cmd = 3'b100; end
         S_STORE: begin
            bus_addr[DW-1:0] = eff_addr;
            bus_cmd          = 3'b101;
            bus_we           = 1'b1;
            bus_wdata        = sel_reg;
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order; all architectural
   // state is reset because the ISA defines registers and flags as 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_F1;
         pc    <= '0;
         opc   <= '0;
         fld   <= '0;
         opnd  <= '0;
         mval  <= '0;
         ra    <= '0;
         rx    <= '0;
         ry    <= '0;
         z     <= 1'b0;
         c     <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            S_F1:   if (bus_ready) opc <= bus_rdata[3:0];
            S_F2:   if (bus_ready) fld <= bus_rdata[3:0];
            S_F3:
               if (bus_ready) begin
                  opnd <= bus_rdata;
                  pc   <= pc + AW'(1);
               end
            S_LOAD: if (bus_ready) mval <= bus_rdata;
            S_EXEC: begin
               if (wr_reg) begin
                  case (fld[3:2])
                     2'b01:   rx <= alu_res;
                     2'b10:   ry <= alu_res;
                     default: ra <= alu_res;
                  endcase
               end
               if (upd_z) z <= (alu_res == '0);
               c <= alu_c;
               if (do_jump) pc <= jmp_tgt;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_cpu_v2.sv
// -----------------------------------------------------------------------------
// tb_nibble_cpu_v2 -- self-checking bench for nibble_cpu_v2 (DW=4, AW=10).
//
// Separate instruction and data memories sit on the bus: fetches read imem,
// LOAD reads dmem, STORE writes dmem. Directed scenarios check cycle-level
// bus behaviour; randomized programs are checked transaction by transaction
// against an instruction-level model of the ISA.
// -----------------------------------------------------------------------------
module tb_nibble_cpu_v2;

   localparam int DW = 4;
   localparam int AW = 10;
   localparam int MW = AW + 2;
   localparam int MSZ = 1 << MW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [MW-1:0] bus_addr;
   logic [2:0]    bus_cmd;
   logic          bus_we;
   logic [DW-1:0] bus_wdata;
   logic [DW-1:0] bus_rdata;
   logic          bus_ready = 1'b1;
   logic          halted;

   nibble_cpu_v2 #(.DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus_addr  (bus_addr),
      .bus_cmd   (bus_cmd),
      .bus_we    (bus_we),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_ready (bus_ready),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] imem [0:MSZ-1];
   logic [DW-1:0] dmem [0:MSZ-1];

   assign bus_rdata = (bus_cmd == 3'b100) ? dmem[bus_addr] : imem[bus_addr];

   typedef struct packed {
      logic [2:0]    cmd;
      logic [MW-1:0] addr;
      logic          we;
      logic [DW-1:0] wdata;
   } txn_t;

   txn_t got[$];
   txn_t exp_q[$];

   int n_cmp = 0;
   int n_err = 0;

   // Bus monitor and data-memory write port.
   always @(posedge clk) begin
      if (rst_n && bus_ready && bus_cmd != 3'b000) begin
         got.push_back({bus_cmd, bus_addr, bus_we, bus_wdata});
         if (bus_cmd == 3'b101) dmem[bus_addr] <= bus_wdata;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- helpers
   task automatic step;
      @(negedge clk);
   endtask

   task automatic clear_mem;
      for (int i = 0; i < MSZ; i++) begin
         imem[i] = '0;
         dmem[i] = '0;
      end
   endtask

   task automatic put_instr(input int pc, input int opc, input int rg,
                            input int mode, input int operand);
      imem[pc*4]     = DW'(opc);
      imem[pc*4 + 1] = DW'((rg << 2) | mode);
      imem[pc*4 + 2] = DW'(operand);
   endtask

   task automatic do_reset;
      bus_ready = 1'b1;
      rst_n     = 1'b0;
      step;
      step;
      rst_n = 1'b1;
   endtask

   task automatic next_f1(output int cyc);
      cyc = 0;
      do begin
         step;
         cyc++;
      end while (bus_cmd !== 3'b001 && cyc < 40);
   endtask

   task automatic wait_cmd(input logic [2:0] cmd, output int cyc);
      cyc = 0;
      while (bus_cmd !== cmd && cyc < 60) begin
         step;
         cyc++;
      end
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset;
      clear_mem;
      bus_ready = 1'b1;
      step;
      rst_n = 1'b0;
      step;
      n_cmp++;
      if ({bus_addr, bus_cmd, bus_we, halted} !== {12'h000, 3'b001, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_outputs: addr=%h cmd=%b we=%b halted=%b, want 000/001/0/0",
                  bus_addr, bus_cmd, bus_we, halted);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (bus_addr !== MW'(i) || bus_cmd !== 3'(i + 1)) begin
            n_err++;
            $display("FAIL reset_fetch%0d: addr=%h cmd=%b, want %h/%b",
                     i, bus_addr, bus_cmd, MW'(i), 3'(i + 1));
         end
         step;
      end
   endtask

   task automatic test_alu_carry;
      int cyc;
      clear_mem;
      put_instr(0, 4'h0, 0, 0, 4'h5);   // LD A #5
      put_instr(1, 4'h2, 0, 0, 4'hC);   // ADD A #C -> A=1, C=1
      put_instr(2, 4'h1, 0, 0, 4'h3);   // ST A 3
      put_instr(3, 4'hA, 0, 0, 4'h9);   // JC #9
      do_reset;
      wait_cmd(3'b101, cyc);
      n_cmp++;
      if (cyc !== 11) begin
         n_err++;
         $display("FAIL alu_store_latency: store at cycle %0d, want 11", cyc);
      end
      n_cmp++;
      if ({bus_addr, bus_wdata, bus_we} !== {12'h003, 4'h1, 1'b1}) begin
         n_err++;
         $display("FAIL alu_store: addr=%h wdata=%h we=%b, want 003/1/1",
                  bus_addr, bus_wdata, bus_we);
      end
      next_f1(cyc);
      n_cmp++;
      if (bus_addr !== 12'h00C || cyc !== 1) begin
         n_err++;
         $display("FAIL st_latency: addr=%h after %0d cycles, want 00C after 1", bus_addr, cyc);
      end
      next_f1(cyc);
      n_cmp++;
      if (bus_addr !== 12'h024 || cyc !== 4) begin
         n_err++;
         $display("FAIL jc_taken: addr=%h after %0d cycles, want 024 after 4", bus_addr, cyc);
      end
   endtask

   task automatic test_wait_states;
      int cyc;
      clear_mem;
      put_instr(0, 4'h0, 0, 0, 4'h7);   // LD A #7
      put_instr(1, 4'h1, 0, 0, 4'hF);   // ST A F
      do_reset;
      step;
      bus_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (bus_addr !== 12'h001 || bus_cmd !== 3'b010) begin
            n_err++;
            $display("FAIL wait_hold%0d: addr=%h cmd=%b, want 001/010", i, bus_addr, bus_cmd);
         end
         if (i == 3) bus_ready = 1'b1;
         step;
      end
      n_cmp++;
      if (bus_cmd !== 3'b011) begin
         n_err++;
         $display("FAIL wait_release: cmd=%b, want 011", bus_cmd);
      end
      wait_cmd(3'b101, cyc);
      n_cmp++;
      if (bus_addr !== 12'h00F || bus_wdata !== 4'h7) begin
         n_err++;
         $display("FAIL wait_result: addr=%h wdata=%h, want 00F/7", bus_addr, bus_wdata);
      end
   endtask

   task automatic test_indexed;
      int cyc;
      clear_mem;
      put_instr(0, 4'h0, 1, 0, 4'hE);   // LD X #E
      put_instr(1, 4'h0, 0, 2, 4'h3);   // LD A [3+X] -> addr 1
      put_instr(2, 4'h1, 0, 0, 4'h0);   // ST A 0
      put_instr(3, 4'hB, 0, 0, 4'h5);   // JNZ #5
      dmem[1] = 4'h9;
      do_reset;
      wait_cmd(3'b100, cyc);
      n_cmp++;
      if (bus_addr !== 12'h001 || cyc !== 7) begin
         n_err++;
         $display("FAIL idx_load: addr=%h at cycle %0d, want 001 at 7", bus_addr, cyc);
      end
      next_f1(cyc);
      n_cmp++;
      if (cyc !== 2 || bus_addr !== 12'h008) begin
         n_err++;
         $display("FAIL mem_latency: %0d cycles to addr %h, want 2 to 008", cyc, bus_addr);
      end
      wait_cmd(3'b101, cyc);
      n_cmp++;
      if (bus_wdata !== 4'h9 || bus_addr !== 12'h000) begin
         n_err++;
         $display("FAIL idx_value: wdata=%h addr=%h, want 9/000", bus_wdata, bus_addr);
      end
      next_f1(cyc);
      next_f1(cyc);
      n_cmp++;
      if (bus_addr !== 12'h014) begin
         n_err++;
         $display("FAIL idx_zflag: next fetch %h, want 014", bus_addr);
      end
   endtask

   task automatic test_branches;
      int cyc;
      clear_mem;
      put_instr(0, 4'h0, 0, 0, 4'hA);   // LD A #A
      put_instr(1, 4'h7, 0, 0, 4'hA);   // CMP A #A -> Z=1, C=1
      put_instr(2, 4'h9, 0, 0, 4'h7);   // JZ #7
      put_instr(7, 4'hB, 0, 0, 4'h7);   // JNZ #7 (not taken)
      put_instr(8, 4'hA, 0, 0, 4'h2);   // JC #2
      do_reset;
      for (int i = 0; i < 3; i++) next_f1(cyc);
      n_cmp++;
      if (bus_addr !== 12'h01C || cyc !== 4) begin
         n_err++;
         $display("FAIL jz_taken: addr=%h after %0d, want 01C after 4", bus_addr, cyc);
      end
      next_f1(cyc);
      n_cmp++;
      if (bus_addr !== 12'h020) begin
         n_err++;
         $display("FAIL jnz_not_taken: addr=%h, want 020", bus_addr);
      end
      next_f1(cyc);
      n_cmp++;
      if (bus_addr !== 12'h008) begin
         n_err++;
         $display("FAIL jc_after_cmp: addr=%h, want 008", bus_addr);
      end
   endtask

   task automatic test_halt_reset;
      int cyc;
      clear_mem;
      put_instr(0, 4'hF, 0, 0, 0);      // HLT
      do_reset;
      step;
      step;
      n_cmp++;
      if (halted !== 1'b0) begin
         n_err++;
         $display("FAIL halt_early: halted=%b in F3, want 0", halted);
      end
      step;
      for (int i = 0; i < 12; i++) begin
         n_cmp++;
         if ({halted, bus_cmd, bus_addr} !== {1'b1, 3'b000, 12'h000}) begin
            n_err++;
            $display("FAIL halt_hold%0d: halted=%b cmd=%b addr=%h, want 1/000/000",
                     i, halted, bus_cmd, bus_addr);
         end
         bus_ready = 1'($urandom_range(0, 1));
         step;
      end
      clear_mem;
      put_instr(0, 4'h0, 0, 0, 4'h3);   // LD A #3
      put_instr(1, 4'h1, 0, 0, 4'h5);   // ST A 5
      do_reset;
      wait_cmd(3'b101, cyc);
      bus_ready = 1'b0;
      step;
      n_cmp++;
      if (bus_we !== 1'b1 || bus_wdata !== 4'h3 || bus_addr !== 12'h005) begin
         n_err++;
         $display("FAIL store_hold: we=%b wdata=%h addr=%h, want 1/3/005",
                  bus_we, bus_wdata, bus_addr);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus_we, bus_cmd, bus_addr, bus_wdata} !== {1'b0, 3'b001, 12'h000, 4'h0}) begin
         n_err++;
         $display("FAIL async_reset: we=%b cmd=%b addr=%h wdata=%h, want 0/001/000/0",
                  bus_we, bus_cmd, bus_addr, bus_wdata);
      end
      step;
      bus_ready = 1'b1;
      rst_n = 1'b1;
      step;
      n_cmp++;
      if (bus_addr !== 12'h001 || bus_cmd !== 3'b010) begin
         n_err++;
         $display("FAIL restart_fetch: addr=%h cmd=%b, want 001/010", bus_addr, bus_cmd);
      end
   endtask

   task automatic test_pc_wrap;
      int cyc;
      clear_mem;
      for (int p = 0; p < (1 << AW); p++) imem[p*4] = 4'hC;   // NOP everywhere
      do_reset;
      for (int i = 0; i < (1 << AW) - 1; i++) next_f1(cyc);
      n_cmp++;
      if (bus_addr !== 12'hFFC) begin
         n_err++;
         $display("FAIL pc_last: addr=%h, want FFC", bus_addr);
      end
      next_f1(cyc);
      n_cmp++;
      if (bus_addr !== 12'h000) begin
         n_err++;
         $display("FAIL pc_wrap: addr=%h, want 000", bus_addr);
      end
   endtask

   // Instruction-level ISA model: produces the expected sequence of completed
   // bus transactions for up to k instructions starting from reset.
   task automatic build_expect(input int k, output bit m_halt);
      int r[3];
      int dref[16];
      int pc, z, c;
      r = '{0, 0, 0};
      pc = 0; z = 0; c = 0;
      m_halt = 1'b0;
      for (int i = 0; i < 16; i++) dref[i] = int'(dmem[i]);
      exp_q.delete();
      for (int n = 0; n < k && !m_halt; n++) begin
         int base, opc, w1, op, rs, mode, addr, v, res;
         base = pc * 4;
         opc  = int'(imem[base]);
         w1   = int'(imem[base + 1]);
         op   = int'(imem[base + 2]);
         rs   = (w1 >> 2) & 3;
         if (rs == 3) rs = 0;
         mode = w1 & 3;
         for (int j = 0; j < 3; j++)
            exp_q.push_back({3'(j + 1), MW'(base + j), 1'b0, 4'h0});
         pc   = (pc + 1) % (1 << AW);
         addr = (mode == 2) ? (op + r[1]) % 16 : op;
         if (opc == 1) begin
            exp_q.push_back({3'b101, MW'(addr), 1'b1, 4'(r[rs])});
            dref[addr] = r[rs];
            continue;
         end
         if (opc == 15) begin
            m_halt = 1'b1;
            continue;
         end
         if (opc >= 12) continue;
         v = op;
         if (mode != 0) begin
            exp_q.push_back({3'b100, MW'(addr), 1'b0, 4'h0});
            v = dref[addr];
         end
         case (opc)
            0: begin r[rs] = v; z = (v == 0); end
            2: begin
               res = r[rs] + v; c = (res > 15); r[rs] = res % 16; z = (r[rs] == 0);
            end
            3, 7: begin
               c = (r[rs] >= v); res = (r[rs] - v + 16) % 16; z = (res == 0);
               if (opc == 3) r[rs] = res;
            end
            4: begin r[rs] = r[rs] & v; z = (r[rs] == 0); end
            5: begin r[rs] = r[rs] | v; z = (r[rs] == 0); end
            6: begin r[rs] = r[rs] ^ v; z = (r[rs] == 0); end
            8: pc = v;
            9: if (z) pc = v;
            10: if (c) pc = v;
            11: if (!z) pc = v;
            default: ;
         endcase
      end
   endtask

   task automatic test_random(input int rounds);
      bit m_halt;
      int cyc;
      for (int rd = 0; rd < rounds; rd++) begin
         clear_mem;
         for (int i = 0; i < MSZ; i++) begin
            imem[i] = DW'($urandom_range(0, 15));
            if ((i % 4) == 0 && imem[i] == 4'hF && $urandom_range(0, 7) != 0)
               imem[i] = 4'hC;
         end
         for (int i = 0; i < 16; i++) dmem[i] = DW'($urandom_range(0, 15));
         build_expect(50, m_halt);
         do_reset;
         got.delete();
         cyc = 0;
         while (got.size() < exp_q.size() && cyc < 4000) begin
            bus_ready = ($urandom_range(0, 3) != 0);
            step;
            cyc++;
         end
         bus_ready = 1'b1;
         step;
         step;
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got.size()) begin
               n_err++;
               $display("FAIL rand%0d_txn%0d: missing, want cmd=%b addr=%h",
                        rd, i, exp_q[i].cmd, exp_q[i].addr);
               break;
            end else if (got[i] !== exp_q[i]) begin
               n_err++;
               $display("FAIL rand%0d_txn%0d: cmd=%b addr=%h we=%b wd=%h, want %b/%h/%b/%h",
                        rd, i, got[i].cmd, got[i].addr, got[i].we, got[i].wdata,
                        exp_q[i].cmd, exp_q[i].addr, exp_q[i].we, exp_q[i].wdata);
            end
         end
         n_cmp++;
         if (halted !== m_halt) begin
            n_err++;
            $display("FAIL rand%0d_halted: halted=%b, want %b", rd, halted, m_halt);
         end
      end
   endtask

   initial begin
      test_reset;
      test_alu_carry;
      test_wait_states;
      test_indexed;
      test_branches;
      test_halt_reset;
      test_pc_wrap;
      test_random(8);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
